// File: rtl/minion_uart_pkg.sv
// Shared constants and state types for the minion UART peripheral.
package minion_uart_pkg;

    localparam int unsigned ADDR_W = 20;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned BYTE_W = 8;
    localparam int unsigned STAT_W = 7;

    // Register selects, taken from bus_addr[3:2]
    localparam logic [1:0] REG_TXDATA  = 2'd0;
    localparam logic [1:0] REG_RXDATA  = 2'd1;
    localparam logic [1:0] REG_STATUS  = 2'd2;
    localparam logic [1:0] REG_DIVISOR = 2'd3;

    // STATUS bit positions
    localparam int unsigned ST_TX_FULL      = 0;
    localparam int unsigned ST_TX_EMPTY     = 1;
    localparam int unsigned ST_TX_BUSY      = 2;
    localparam int unsigned ST_RX_VALID     = 3;
    localparam int unsigned ST_RX_OVERRUN   = 4;
    localparam int unsigned ST_TX_DROP      = 5;
    localparam int unsigned ST_RX_FRAME_ERR = 6;

    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

    // Word-register select within the 1 MiB slot; other offset bits alias
    function automatic logic [1:0] reg_sel(input logic [ADDR_W-1:0] addr);
        return addr[3:2];
    endfunction

endpackage

// File: rtl/minion_uart_if.sv
// Decoded per-slot peripheral bus: strobe, offset, write data and registered read data.
interface minion_uart_if import minion_uart_pkg::*; ();

    logic              bus_ce;
    logic              bus_we;
    logic [ADDR_W-1:0] bus_addr;
    logic [DATA_W-1:0] bus_write;
    logic [DATA_W-1:0] bus_read;

    modport master (
        output bus_ce,
        output bus_we,
        output bus_addr,
        output bus_write,
        input  bus_read
    );

    modport slave (
        input  bus_ce,
        input  bus_we,
        input  bus_addr,
        input  bus_write,
        output bus_read
    );

endinterface

// File: rtl/minion_sync_fifo.sv
// Single-clock first-word-fall-through FIFO; push is accepted when full if a pop happens the same cycle.
module minion_sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Extra pointer bit separates the full and empty cases when indices match
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rd_ptr[AW-1:0]];

    // Pointer update
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    // Storage write; contents need no reset
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/minion_uart_periph.sv
// UART peripheral for one minion bus slot: TX FIFO + 8N1 serialiser, 8N1 deserialiser + holding register.
module minion_uart_periph import minion_uart_pkg::*; #(
    parameter int unsigned     TX_DEPTH    = 16,
    parameter int unsigned     DIV_W       = 16,
    parameter logic [DIV_W-1:0] DEFAULT_DIV = DIV_W'(433)
) (
    input  logic         clk,
    input  logic         rst,
    minion_uart_if.slave bus,
    input  logic         uart_rx,
    output logic         uart_tx,
    output logic         irq
);

    // Bus decode
    logic       wr_en;
    logic       rd_en;
    logic [1:0] sel;
    logic       tx_wr;
    logic       rx_rd;
    logic       st_wr;
    logic       div_wr;
    logic       unused_bus;

    assign sel    = reg_sel(bus.bus_addr);
    assign wr_en  = bus.bus_ce & bus.bus_we;
    assign rd_en  = bus.bus_ce & ~bus.bus_we;
    assign tx_wr  = wr_en && (sel == REG_TXDATA);
    assign rx_rd  = rd_en && (sel == REG_RXDATA);
    assign st_wr  = wr_en && (sel == REG_STATUS);
    assign div_wr = wr_en && (sel == REG_DIVISOR);
    assign unused_bus = ^{bus.bus_addr, bus.bus_write};

    // Register state
    logic [DIV_W-1:0]  div_q;
    logic [BYTE_W-1:0] rx_byte;
    logic              rx_valid;
    logic              rx_overrun;
    logic              tx_drop;
    logic              rx_frame_err;

    // TX path state
    tx_state_t         tx_state;
    logic [DIV_W-1:0]  tx_cnt;
    logic [BYTE_W-1:0] tx_shift;
    logic [2:0]        tx_bit;
    logic              tx_pop;
    logic              tx_busy;
    logic [BYTE_W-1:0] fifo_rdata;
    logic              fifo_full;
    logic              fifo_empty;

    // RX path state
    rx_state_t         rx_state;
    logic [DIV_W-1:0]  rx_cnt;
    logic [BYTE_W-1:0] rx_shift;
    logic [2:0]        rx_bit;
    logic              rx_s1;
    logic              rx_s2;
    logic              rx_prev;
    logic              rx_stop_ok;
    logic              rx_stop_bad;

    minion_sync_fifo #(
        .WIDTH (BYTE_W),
        .DEPTH (TX_DEPTH)
    ) u_tx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (tx_wr),
        .wdata (bus.bus_write[BYTE_W-1:0]),
        .pop   (tx_pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // The serialiser takes the next byte when idle or at the last cycle of a stop bit
    assign tx_pop  = !fifo_empty &&
                     ((tx_state == TX_IDLE) || ((tx_state == TX_STOP) && (tx_cnt == '0)));
    assign tx_busy = (tx_state != TX_IDLE);

    // TX FSM: start, 8 data bits LSB first, stop; each bit lasts div_q+1 clocks
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_state <= TX_IDLE;
            tx_cnt   <= '0;
            tx_shift <= '0;
            tx_bit   <= '0;
            uart_tx  <= 1'b1;
        end else begin
            case (tx_state)
                TX_IDLE: begin
                    if (tx_pop) begin
                        tx_state <= TX_START;
                        tx_cnt   <= div_q;
                        tx_shift <= fifo_rdata;
                        uart_tx  <= 1'b0;
                    end
                end
                TX_START: begin
                    if (tx_cnt == '0) begin
                        tx_state <= TX_DATA;
                        tx_cnt   <= div_q;
                        tx_bit   <= '0;
                        uart_tx  <= tx_shift[0];
                    end else begin
                        tx_cnt <= tx_cnt - DIV_W'(1);
                    end
                end
                TX_DATA: begin
                    if (tx_cnt == '0) begin
                        tx_cnt <= div_q;
                        if (tx_bit == 3'd7) begin
                            tx_state <= TX_STOP;
                            uart_tx  <= 1'b1;
                        end else begin
                            tx_bit   <= tx_bit + 3'd1;
                            tx_shift <= tx_shift >> 1;
                            uart_tx  <= tx_shift[1];
                        end
                    end else begin
                        tx_cnt <= tx_cnt - DIV_W'(1);
                    end
                end
                TX_STOP: begin
                    if (tx_cnt == '0) begin
                        if (tx_pop) begin
                            tx_state <= TX_START;
                            tx_cnt   <= div_q;
                            tx_shift <= fifo_rdata;
                            uart_tx  <= 1'b0;
                        end else begin
                            tx_state <= TX_IDLE;
                        end
                    end else begin
                        tx_cnt <= tx_cnt - DIV_W'(1);
                    end
                end
                default: begin
                    tx_state <= TX_IDLE;
                    uart_tx  <= 1'b1;
                end
            endcase
        end
    end

    // Two-flop synchroniser plus one delayed copy for falling-edge detection
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_s1   <= 1'b1;
            rx_s2   <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_s1   <= uart_rx;
            rx_s2   <= rx_s1;
            rx_prev <= rx_s2;
        end
    end

    assign rx_stop_ok  = (rx_state == RX_STOP) && (rx_cnt == '0) &&  rx_s2;
    assign rx_stop_bad = (rx_state == RX_STOP) && (rx_cnt == '0) && !rx_s2;

    // RX FSM: half-bit start check, then mid-bit samples every div_q+1 clocks
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_state <= RX_IDLE;
            rx_cnt   <= '0;
            rx_shift <= '0;
            rx_bit   <= '0;
        end else begin
            case (rx_state)
                RX_IDLE: begin
                    if (rx_prev && !rx_s2) begin
                        rx_state <= RX_START;
                        rx_cnt   <= div_q >> 1;
                    end
                end
                RX_START: begin
                    if (rx_cnt == '0) begin
                        if (!rx_s2) begin
                            rx_state <= RX_DATA;
                            rx_cnt   <= div_q;
                            rx_bit   <= '0;
                        end else begin
                            rx_state <= RX_IDLE;
                        end
                    end else begin
                        rx_cnt <= rx_cnt - DIV_W'(1);
                    end
                end
                RX_DATA: begin
                    if (rx_cnt == '0) begin
                        rx_shift <= {rx_s2, rx_shift[BYTE_W-1:1]};
                        rx_cnt   <= div_q;
                        if (rx_bit == 3'd7) rx_state <= RX_STOP;
                        else                rx_bit   <= rx_bit + 3'd1;
                    end else begin
                        rx_cnt <= rx_cnt - DIV_W'(1);
                    end
                end
                RX_STOP: begin
                    if (rx_cnt == '0) rx_state <= RX_IDLE;
                    else              rx_cnt   <= rx_cnt - DIV_W'(1);
                end
                default: rx_state <= RX_IDLE;
            endcase
        end
    end

    // Status view of live state and sticky flags
    logic [STAT_W-1:0] status_c;

    always_comb begin
        status_c                  = '0;
        status_c[ST_TX_FULL]      = fifo_full;
        status_c[ST_TX_EMPTY]     = fifo_empty;
        status_c[ST_TX_BUSY]      = tx_busy;
        status_c[ST_RX_VALID]     = rx_valid;
        status_c[ST_RX_OVERRUN]   = rx_overrun;
        status_c[ST_TX_DROP]      = tx_drop;
        status_c[ST_RX_FRAME_ERR] = rx_frame_err;
    end

    // Register file, sticky flags (a set beats a same-edge clear) and registered read data
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_q        <= DEFAULT_DIV;
            rx_byte      <= '0;
            rx_valid     <= 1'b0;
            rx_overrun   <= 1'b0;
            tx_drop      <= 1'b0;
            rx_frame_err <= 1'b0;
            bus.bus_read <= '0;
        end else begin
            if (div_wr) div_q <= bus.bus_write[DIV_W-1:0];

            if (rx_stop_ok) begin
                rx_byte  <= rx_shift;
                rx_valid <= 1'b1;
            end else if (rx_rd) begin
                rx_valid <= 1'b0;
            end

            rx_overrun   <= (rx_overrun   & ~(st_wr & bus.bus_write[ST_RX_OVERRUN]))
                          | (rx_stop_ok & rx_valid & ~rx_rd);
            tx_drop      <= (tx_drop      & ~(st_wr & bus.bus_write[ST_TX_DROP]))
                          | (tx_wr & fifo_full & ~tx_pop);
            rx_frame_err <= (rx_frame_err & ~(st_wr & bus.bus_write[ST_RX_FRAME_ERR]))
                          | rx_stop_bad;

            if (rd_en) begin
                case (sel)
                    REG_RXDATA:  bus.bus_read <= DATA_W'({rx_valid, rx_byte});
                    REG_STATUS:  bus.bus_read <= DATA_W'(status_c);
                    REG_DIVISOR: bus.bus_read <= DATA_W'(div_q);
                    default:     bus.bus_read <= '0;
                endcase
            end
        end
    end

    assign irq = rx_valid;

endmodule

// File: tb/tb_minion_uart_periph.sv
// Directed bench for minion_uart_periph: register access, TX framing, FIFO limits, RX paths, loopback.
module tb_minion_uart_periph;
    import minion_uart_pkg::*;

    localparam logic [19:0] A_TX  = 20'h0;
    localparam logic [19:0] A_RX  = 20'h4;
    localparam logic [19:0] A_ST  = 20'h8;
    localparam logic [19:0] A_DIV = 20'hC;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic uart_rx;
    logic uart_tx;
    logic irq;
    logic rx_drv   = 1'b1;
    logic loopback = 1'b0;

    int n_cmp = 0;
    int n_err = 0;

    minion_uart_if bus_if ();

    assign uart_rx = loopback ? uart_tx : rx_drv;

    minion_uart_periph #(
        .TX_DEPTH    (16),
        .DIV_W       (16),
        .DEFAULT_DIV (16'd433)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus_if),
        .uart_rx (uart_rx),
        .uart_tx (uart_tx),
        .irq     (irq)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic bus_wr(input logic [19:0] a, input logic [31:0] d);
        @(negedge clk);
        bus_if.bus_ce    = 1'b1;
        bus_if.bus_we    = 1'b1;
        bus_if.bus_addr  = a;
        bus_if.bus_write = d;
        @(negedge clk);
        bus_if.bus_ce    = 1'b0;
        bus_if.bus_we    = 1'b0;
    endtask

    task automatic bus_rd(input logic [19:0] a, output logic [31:0] d);
        @(negedge clk);
        bus_if.bus_ce   = 1'b1;
        bus_if.bus_we   = 1'b0;
        bus_if.bus_addr = a;
        @(negedge clk);
        bus_if.bus_ce   = 1'b0;
        d = bus_if.bus_read;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Drive one 8N1 frame on uart_rx with a chosen stop-bit level
    task automatic rx_send(input logic [7:0] b, input logic stop, input int bclk);
        logic [9:0] frame;
        frame = {stop, b, 1'b0};
        @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            rx_drv = frame[i];
            repeat (bclk) @(negedge clk);
        end
        rx_drv = 1'b1;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d;
        logic [7:0]  txb;
        logic [7:0]  loop_exp [3];
        int          got;
        int          budget;

        bus_if.bus_ce    = 1'b0;
        bus_if.bus_we    = 1'b0;
        bus_if.bus_addr  = '0;
        bus_if.bus_write = '0;

        // Reset state
        idle(3);
        rst = 1'b0;
        idle(2);
        check_eq("rst_uart_tx", 32'(uart_tx), 32'h1);
        check_eq("rst_irq", 32'(irq), 32'h0);
        check_eq("rst_bus_read", bus_if.bus_read, 32'h0);
        bus_rd(A_ST, d);  check_eq("rst_status", d, 32'h02);
        bus_rd(A_DIV, d); check_eq("rst_divisor", d, 32'd433);
        bus_rd(A_TX, d);  check_eq("txdata_reads_zero", d, 32'h0);

        // TX frame of 0xA5 at 4 clocks per bit
        bus_wr(A_DIV, 32'd3);
        bus_rd(A_DIV, d); check_eq("div_readback3", d, 32'd3);
        txb = 8'hA5;
        bus_wr(A_TX, 32'hA5);
        for (int k = 0; k < 40; k++) begin
            logic exp_b;
            @(negedge clk);
            if (k < 4)       exp_b = 1'b0;
            else if (k < 36) exp_b = txb[(k / 4) - 1];
            else             exp_b = 1'b1;
            check_eq($sformatf("tx_a5_clk%0d", k), 32'(uart_tx), 32'(exp_b));
        end
        bus_rd(A_ST, d); check_eq("tx_busy_fell", d, 32'h02);
        check_eq("tx_idle_high", 32'(uart_tx), 32'h1);

        // Reset in the middle of a start bit
        bus_wr(A_TX, 32'h0F);
        @(negedge clk);
        check_eq("mid_frame_low", 32'(uart_tx), 32'h0);
        rst = 1'b1;
        #1;
        check_eq("rst_abort_tx_high", 32'(uart_tx), 32'h1);
        @(negedge clk);
        rst = 1'b0;
        bus_rd(A_ST, d);  check_eq("rst2_status", d, 32'h02);
        bus_rd(A_DIV, d); check_eq("rst2_divisor", d, 32'd433);

        // FIFO full: one byte in flight, then 17 writes; 16 fit, the last drops
        bus_wr(A_TX, 32'h11);
        idle(3);
        for (int i = 0; i < 17; i++) bus_wr(A_TX, 32'(i));
        bus_rd(A_ST, d); check_eq("fifo_full_status", d, 32'h25);
        bus_wr(A_ST, 32'h20);
        bus_rd(A_ST, d); check_eq("tx_drop_w1c", d, 32'h05);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        idle(1);

        // RX single byte at 8 clocks per bit
        bus_wr(A_DIV, 32'd7);
        bus_rd(A_DIV, d); check_eq("div_readback7", d, 32'd7);
        rx_send(8'h3C, 1'b1, 8);
        idle(4);
        check_eq("rx_irq_set", 32'(irq), 32'h1);
        bus_rd(A_RX, d); check_eq("rx_first_read", d, 32'h13C);
        check_eq("rx_irq_clear", 32'(irq), 32'h0);
        bus_rd(A_RX, d); check_eq("rx_second_read", d, 32'h03C);

        // Overrun: two frames without a read
        rx_send(8'h11, 1'b1, 8);
        idle(2);
        rx_send(8'h22, 1'b1, 8);
        idle(4);
        bus_rd(A_ST, d); check_eq("overrun_status", d, 32'h1A);
        bus_rd(A_RX, d); check_eq("overrun_data", d, 32'h122);
        bus_wr(A_ST, 32'h10);
        bus_rd(A_ST, d); check_eq("overrun_w1c", d, 32'h02);

        // Frame error leaves the held byte and rx_valid alone
        rx_send(8'h33, 1'b1, 8);
        idle(2);
        rx_send(8'h44, 1'b0, 8);
        idle(4);
        bus_rd(A_ST, d); check_eq("frame_err_status", d, 32'h4A);
        bus_rd(A_RX, d); check_eq("frame_err_data", d, 32'h133);
        bus_wr(A_ST, 32'h40);
        bus_rd(A_ST, d); check_eq("frame_err_w1c", d, 32'h02);

        // Two-clock glitch is rejected and RX still receives afterwards
        @(negedge clk);
        rx_drv = 1'b0;
        idle(2);
        rx_drv = 1'b1;
        idle(20);
        bus_rd(A_ST, d); check_eq("glitch_status", d, 32'h02);
        check_eq("glitch_irq", 32'(irq), 32'h0);
        rx_send(8'h5A, 1'b1, 8);
        idle(4);
        bus_rd(A_RX, d); check_eq("post_glitch_data", d, 32'h15A);

        // Loopback at 2 clocks per bit, three back-to-back bytes
        bus_wr(A_DIV, 32'd1);
        loopback = 1'b1;
        idle(2);
        loop_exp[0] = 8'h00;
        loop_exp[1] = 8'hFF;
        loop_exp[2] = 8'h55;
        bus_wr(A_TX, 32'h00);
        bus_wr(A_TX, 32'hFF);
        bus_wr(A_TX, 32'h55);
        got    = 0;
        budget = 0;
        while (got < 3 && budget < 300) begin
            bus_rd(A_RX, d);
            budget++;
            if (d[8]) begin
                check_eq($sformatf("loop_byte%0d", got), 32'(d[7:0]), 32'(loop_exp[got]));
                got++;
            end
        end
        check_eq("loop_count", 32'(got), 32'd3);
        idle(10);
        bus_rd(A_ST, d); check_eq("loop_status", d, 32'h02);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
